// File: rtl/text_cursor_ctrl.sv
// text_cursor_ctrl: keyboard-driven text cursor with RAM writes and full-screen clear sweep
module text_cursor_ctrl #(
  parameter int COLS = 80,
  parameter int ROWS = 48,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  input  logic        key_enter,
  input  logic        key_tab,
  input  logic        key_bs,
  input  logic        clear_req,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic [6:0]  cursor_col,
  output logic [5:0]  cursor_row,
  output logic        busy,
  output logic        clear_done
);
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam logic [6:0]  CMAX = 7'(COLS - 1);
  localparam logic [5:0]  RMAX = 6'(ROWS - 1);
  localparam logic [11:0] AMAX = 12'(COLS * ROWS - 1);
  state_t state, state_n;
  logic [6:0] col_n, adv_col, ret_col, tab_col;
  logic [5:0] row_n, adv_row, ret_row, nl_row;
  logic we_n, busy_n, done_n;
  logic [11:0] addr_n;
  logic [7:0] data_n;
  // row*80 as (row<<6)+(row<<4)
  function automatic logic [11:0] addr_of(input logic [5:0] r, input logic [6:0] c);
    return ({6'd0, r} << 6) + ({6'd0, r} << 4) + {5'd0, c};
  endfunction
  always_comb begin
    nl_row  = (cursor_row == RMAX) ? '0 : cursor_row + 6'd1;
    adv_col = (cursor_col == CMAX) ? '0 : cursor_col + 7'd1;
    adv_row = (cursor_col == CMAX) ? nl_row : cursor_row;
    ret_col = (cursor_col != '0) ? cursor_col - 7'd1 : (cursor_row != '0) ? CMAX : '0;
    ret_row = (cursor_col == '0 && cursor_row != '0) ? cursor_row - 6'd1 : cursor_row;
    tab_col = {cursor_col[6:3] + 4'd1, 3'b000};
  end
  always_comb begin
    state_n = state;
    col_n   = cursor_col;
    row_n   = cursor_row;
    we_n    = 1'b0;
    addr_n  = ram_addr;
    data_n  = ram_data;
    busy_n  = busy;
    done_n  = 1'b0;
    if (state == CLEAR) begin
      if (ram_addr == AMAX) begin
        state_n = IDLE;
        busy_n  = 1'b0;
        done_n  = 1'b1;
        col_n   = '0;
        row_n   = '0;
      end else begin
        we_n   = 1'b1;
        addr_n = ram_addr + 12'd1;
        data_n = BLANK;
      end
    end else if (clear_req) begin
      state_n = CLEAR;
      busy_n  = 1'b1;
      we_n    = 1'b1;
      addr_n  = '0;
      data_n  = BLANK;
    end else if (key_valid) begin
      if (key_bs) begin
        col_n  = ret_col;
        row_n  = ret_row;
        we_n   = 1'b1;
        addr_n = addr_of(ret_row, ret_col);
        data_n = BLANK;
      end else if (key_enter || (key_tab && tab_col >= 7'(COLS))) begin
        col_n = '0;
        row_n = nl_row;
      end else if (key_tab) begin
        col_n = tab_col;
      end else begin
        col_n  = adv_col;
        row_n  = adv_row;
        we_n   = 1'b1;
        addr_n = addr_of(cursor_row, cursor_col);
        data_n = key_code;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cursor_col <= '0;
      cursor_row <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_n;
      cursor_col <= col_n;
      cursor_row <= row_n;
      ram_we     <= we_n;
      ram_addr   <= addr_n;
      ram_data   <= data_n;
      busy       <= busy_n;
      clear_done <= done_n;
    end
  end
endmodule

// File: tb/tb_text_cursor_ctrl.sv
// tb_text_cursor_ctrl: vector table plus scoreboard checks of cursor moves, writes, clear and reset
module tb_text_cursor_ctrl;
  localparam int COLS = 80;
  localparam int ROWS = 48;
  localparam int N = COLS * ROWS;
  localparam logic [7:0] BLANK = 8'h20;
  logic clk = 1'b0, rst_n = 1'b0;
  logic key_valid = 1'b0, key_enter = 1'b0, key_tab = 1'b0, key_bs = 1'b0, clear_req = 1'b0;
  logic [7:0] key_code = '0;
  logic ram_we, busy, clear_done;
  logic [11:0] ram_addr;
  logic [7:0] ram_data;
  logic [6:0] cursor_col;
  logic [5:0] cursor_row;
  always #5 clk = ~clk;
  text_cursor_ctrl dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .key_enter(key_enter), .key_tab(key_tab), .key_bs(key_bs), .clear_req(clear_req),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy), .clear_done(clear_done)
  );
  typedef struct {
    logic we; logic [11:0] addr; logic [7:0] data;
    logic busy; logic done; logic cur; logic [6:0] col; logic [5:0] row;
  } exp_t;
  typedef struct {
    logic bs; logic en; logic tb; logic [7:0] code;
    logic we; logic [11:0] addr; logic [7:0] data; logic [6:0] col; logic [5:0] row;
  } vec_t;
  exp_t q[$];
  vec_t tbl[25];
  int n_cmp = 0, n_bad = 0;
  int p = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask
  task automatic push(input logic we, input int addr, input logic [7:0] data, input logic b,
                      input logic d, input logic cur, input int col, input int row);
    exp_t e;
    e.we = we; e.addr = 12'(addr); e.data = data; e.busy = b; e.done = d;
    e.cur = cur; e.col = 7'(col); e.row = 6'(row);
    q.push_back(e);
  endtask
  task automatic check_pop(input string name);
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty, got we=%0b want an entry", name, ram_we);
      return;
    end
    e = q.pop_front();
    chk({name, ".we"}, 32'(ram_we), 32'(e.we));
    if (e.we) begin
      chk({name, ".addr"}, 32'(ram_addr), 32'(e.addr));
      chk({name, ".data"}, 32'(ram_data), 32'(e.data));
    end
    chk({name, ".busy"}, 32'(busy), 32'(e.busy));
    chk({name, ".done"}, 32'(clear_done), 32'(e.done));
    if (e.cur) begin
      chk({name, ".col"}, 32'(cursor_col), 32'(e.col));
      chk({name, ".row"}, 32'(cursor_row), 32'(e.row));
    end
  endtask
  task automatic drive(input logic v, input logic bs, input logic en, input logic tb,
                       input logic clr, input logic [7:0] code);
    @(negedge clk);
    key_valid = v; key_bs = bs; key_enter = en; key_tab = tb; clear_req = clr; key_code = code;
    @(posedge clk);
    #1;
    key_valid = 0; key_bs = 0; key_enter = 0; key_tab = 0; clear_req = 0; key_code = '0;
  endtask
  // linear-position reference: kind 0 char, 1 backspace, 2 enter, 3 tab
  task automatic nav(input int kind, input logic [7:0] code, input string name);
    int c, r, t, a;
    logic we;
    logic [7:0] d;
    c = p % COLS; r = p / COLS; we = 0; a = 0; d = '0;
    case (kind)
      0: begin we = 1; a = p; d = code; p = (p + 1) % N; end
      1: begin p = (p == 0) ? 0 : p - 1; we = 1; a = p; d = BLANK; end
      2: p = ((r + 1) % ROWS) * COLS;
      default: begin
        t = (c / 8 + 1) * 8;
        p = (t >= COLS) ? ((r + 1) % ROWS) * COLS : r * COLS + t;
      end
    endcase
    push(we, a, d, 0, 0, 1, p % COLS, p / COLS);
    drive(1, kind == 1, kind == 2, kind == 3, 0, code);
    check_pop(name);
  endtask
  task automatic chk_reset(input string name);
    chk({name, ".we"}, 32'(ram_we), 0);
    chk({name, ".addr"}, 32'(ram_addr), 0);
    chk({name, ".data"}, 32'(ram_data), 0);
    chk({name, ".col"}, 32'(cursor_col), 0);
    chk({name, ".row"}, 32'(cursor_row), 0);
    chk({name, ".busy"}, 32'(busy), 0);
    chk({name, ".done"}, 32'(clear_done), 0);
  endtask
  task automatic start_clear(input string name);
    push(1, 0, BLANK, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 8'h99);
    check_pop(name);
  endtask
  initial begin
    tbl[0]  = '{0, 0, 0, 8'h41, 1, 0,   8'h41, 1,  0};
    tbl[1]  = '{1, 0, 0, 8'h00, 1, 0,   BLANK, 0,  0};
    tbl[2]  = '{1, 0, 0, 8'h00, 1, 0,   BLANK, 0,  0};
    tbl[3]  = '{0, 1, 0, 8'h00, 0, 0,   8'h00, 0,  1};
    tbl[4]  = '{1, 0, 0, 8'h00, 1, 79,  BLANK, 79, 0};
    tbl[5]  = '{0, 0, 0, 8'h7a, 1, 79,  8'h7a, 0,  1};
    tbl[6]  = '{0, 1, 0, 8'h31, 0, 0,   8'h00, 0,  2};
    tbl[7]  = '{0, 1, 0, 8'h00, 0, 0,   8'h00, 0,  3};
    tbl[8]  = '{0, 0, 1, 8'h00, 0, 0,   8'h00, 8,  3};
    tbl[9]  = '{0, 0, 0, 8'h62, 1, 248, 8'h62, 9,  3};
    tbl[10] = '{0, 0, 0, 8'h63, 1, 249, 8'h63, 10, 3};
    tbl[11] = '{0, 0, 1, 8'h00, 0, 0,   8'h00, 16, 3};
    tbl[12] = '{0, 0, 1, 8'h00, 0, 0,   8'h00, 24, 3};
    tbl[13] = '{0, 0, 1, 8'h00, 0, 0,   8'h00, 32, 3};
    tbl[14] = '{0, 0, 1, 8'h00, 0, 0,   8'h00, 40, 3};
    tbl[15] = '{0, 0, 1, 8'h00, 0, 0,   8'h00, 48, 3};
    tbl[16] = '{0, 0, 1, 8'h00, 0, 0,   8'h00, 56, 3};
    tbl[17] = '{0, 0, 1, 8'h00, 0, 0,   8'h00, 64, 3};
    tbl[18] = '{0, 0, 1, 8'h00, 0, 0,   8'h00, 72, 3};
    tbl[19] = '{0, 0, 0, 8'h64, 1, 312, 8'h64, 73, 3};
    tbl[20] = '{0, 0, 0, 8'h65, 1, 313, 8'h65, 74, 3};
    tbl[21] = '{0, 0, 0, 8'h66, 1, 314, 8'h66, 75, 3};
    tbl[22] = '{0, 0, 1, 8'h00, 0, 0,   8'h00, 0,  4};
    tbl[23] = '{1, 1, 1, 8'h77, 1, 319, BLANK, 79, 3};
    tbl[24] = '{0, 1, 1, 8'h78, 0, 0,   8'h00, 0,  4};
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      push(tbl[i].we, int'(tbl[i].addr), tbl[i].data, 0, 0, 1, int'(tbl[i].col), int'(tbl[i].row));
      drive(1, tbl[i].bs, tbl[i].en, tbl[i].tb, 0, tbl[i].code);
      check_pop($sformatf("vec%0d", i));
      p = int'(tbl[i].row) * COLS + int'(tbl[i].col);
    end
    for (int i = 0; i < 43; i++) nav(2, 8'h00, "nav_enter");
    for (int i = 0; i < 9; i++) nav(3, 8'h00, "nav_tab");
    for (int i = 0; i < 7; i++) nav(0, 8'(8'h30 + i), "nav_char");
    push(1, 3839, 8'h55, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 8'h55);
    check_pop("wrap_end");
    p = 0;
    for (int i = 0; i < 47; i++) nav(2, 8'h00, "nav_enter2");
    for (int i = 0; i < 5; i++) nav(0, 8'h61, "nav_char2");
    push(0, 0, 8'h00, 0, 0, 1, 0, 0);
    drive(1, 0, 1, 0, 0, 8'h00);
    check_pop("enter_wrap");
    p = 0;
    nav(0, 8'h42, "pre_clear");
    start_clear("clr_first");
    for (int i = 1; i < N; i++) begin
      push(1, i, BLANK, 1, 0, 0, 0, 0);
      @(negedge clk);
      key_valid = 1'($urandom_range(0, 1)); clear_req = 1'($urandom_range(0, 1));
      key_bs = 1'($urandom_range(0, 1)); key_code = 8'($urandom);
      @(posedge clk);
      #1;
      key_valid = 0; clear_req = 0; key_bs = 0; key_code = '0;
      check_pop("clr_sweep");
    end
    push(0, 0, 8'h00, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 8'h00);
    check_pop("clr_done");
    push(0, 0, 8'h00, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 8'h00);
    check_pop("done_low");
    p = 0;
    nav(0, 8'h43, "pre_abort");
    start_clear("abort_first");
    for (int i = 1; i <= 1000; i++) begin
      push(1, i, BLANK, 1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 8'h00);
      check_pop("abort_sweep");
    end
    #2 rst_n = 1'b0;
    #1 chk_reset("abort_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(0, 0, 8'h00, 0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 8'h00);
      check_pop("post_abort_idle");
    end
    p = 0;
    nav(0, 8'h51, "after_abort");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
